sobolrng_md: RTL and testbench

//  Multi-dimension, fully parametrised Sobol RNG for unary/stochastic multipliers.
//  One shared index counter drives NUM_DIM independent Gray-code XOR accumulators.

---
 rtl/sobolrng_pkg.sv | 18 +
 rtl/sobolrng_md_lsz.sv | 12 +
 rtl/sobolrng_md.sv | 106 ++++++++++
 tb/tb_sobolrng_md.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobolrng_pkg.sv
// rtl/sobolrng_pkg.sv - shared helpers for the multi-dimension Sobol generator
package sobolrng_pkg;

  localparam int MAX_BITWIDTH = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Default direction vector k: a single bit walking down from the MSB (van der Corput)
  function automatic logic [MAX_BITWIDTH-1:0] dv_default(input int k, input int bitwidth);
    return MAX_BITWIDTH'(1) << (bitwidth - 1 - k);
  endfunction

endpackage

// File: rtl/sobolrng_md_lsz.sv
// rtl/sobolrng_md_lsz.sv - one-hot position of the least-significant zero of a vector
module lsz #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_vec,
  output logic [W-1:0] o_onehot
);

  // Adding one ripples through the trailing ones; the first zero becomes the only new one
  assign o_onehot = ~i_vec & (i_vec + W'(1));

endmodule

// File: rtl/sobolrng_md.sv
// rtl/sobolrng_md.sv - multi-dimension Sobol RNG with a shared index and writable direction vectors
module sobolrng_md
  import sobolrng_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int NUM_DIM  = 2,
  parameter int DIMW     = (NUM_DIM > 1) ? clog2(NUM_DIM) : 1,
  parameter int IDXW     = clog2(BITWIDTH)
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iEn,
  input  logic                        iClr,
  input  logic                        iDvWe,
  input  logic [DIMW-1:0]             iDvDim,
  input  logic [IDXW-1:0]             iDvIdx,
  input  logic [BITWIDTH-1:0]         iDvData,
  output logic [NUM_DIM*BITWIDTH-1:0] oRand,
  output logic [BITWIDTH-1:0]         oCnt,
  output logic                        oWrap
);

  typedef logic [BITWIDTH-1:0] word_t;

  word_t cnt_q, cnt_d;
  logic  wrap_q, wrap_d;
  word_t smp_q [NUM_DIM];
  word_t smp_d [NUM_DIM];
  word_t dv_q  [NUM_DIM][BITWIDTH];
  word_t dv_d  [NUM_DIM][BITWIDTH];
  word_t step_v [NUM_DIM];

  word_t lsz_onehot;
  word_t sel;
  logic  cnt_full;
  logic  dv_wr_ok;

  lsz #(.W(BITWIDTH)) u_lsz (
    .i_vec    (cnt_q),
    .o_onehot (lsz_onehot)
  );

  // All-ones has no zero; pick the top vector so the sequence lands exactly on 0
  assign cnt_full = &cnt_q;
  assign sel      = cnt_full ? (word_t'(1) << (BITWIDTH - 1)) : lsz_onehot;

  // Dimension 0 stays fixed as the van der Corput reference
  assign dv_wr_ok = iDvWe && (iDvDim != '0) && (int'(iDvDim) < NUM_DIM) &&
                    (int'(iDvIdx) < BITWIDTH);

  always_comb begin
    for (int d = 0; d < NUM_DIM; d++) begin
      step_v[d] = '0;
      for (int k = 0; k < BITWIDTH; k++) begin
        if (sel[k]) step_v[d] = step_v[d] | dv_q[d][k];
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    for (int d = 0; d < NUM_DIM; d++) begin
      smp_d[d] = smp_q[d];
      for (int k = 0; k < BITWIDTH; k++) begin
        dv_d[d][k] = dv_q[d][k];
        if (dv_wr_ok && (int'(iDvDim) == d) && (int'(iDvIdx) == k)) dv_d[d][k] = iDvData;
      end
    end

    if (iClr) begin
      cnt_d = '0;
      for (int d = 0; d < NUM_DIM; d++) smp_d[d] = '0;
    end else if (iEn) begin
      cnt_d  = cnt_q + word_t'(1);
      wrap_d = cnt_full;
      for (int d = 0; d < NUM_DIM; d++) smp_d[d] = smp_q[d] ^ step_v[d];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      for (int d = 0; d < NUM_DIM; d++) begin
        smp_q[d] <= '0;
        for (int k = 0; k < BITWIDTH; k++) dv_q[d][k] <= word_t'(dv_default(k, BITWIDTH));
      end
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      for (int d = 0; d < NUM_DIM; d++) begin
        smp_q[d] <= smp_d[d];
        for (int k = 0; k < BITWIDTH; k++) dv_q[d][k] <= dv_d[d][k];
      end
    end
  end

  for (genvar g = 0; g < NUM_DIM; g++) begin : g_out
    assign oRand[g*BITWIDTH +: BITWIDTH] = smp_q[g];
  end

  assign oCnt  = cnt_q;
  assign oWrap = wrap_q;

endmodule

// File: tb/tb_sobolrng_md.sv
// tb/tb_sobolrng_md.sv - self-checking bench for sobolrng_md against a Gray-code Sobol model
module tb_sobolrng_md;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_en = 1'b0, a_clr = 1'b0, a_we = 1'b0;
  logic [0:0]  a_dim = '0;
  logic [2:0]  a_idx = '0;
  logic [7:0]  a_data = '0;
  logic [15:0] a_rand;
  logic [7:0]  a_cnt;
  logic        a_wrap;

  logic        b_rst = 1'b1, b_en = 1'b0, b_clr = 1'b0, b_we = 1'b0;
  logic [1:0]  b_dim = '0;
  logic [2:0]  b_idx = '0;
  logic [4:0]  b_data = '0;
  logic [14:0] b_rand;
  logic [4:0]  b_cnt;
  logic        b_wrap;

  sobolrng_md #(.BITWIDTH(8), .NUM_DIM(2)) dut_a (
    .iClk(clk), .iRst(a_rst), .iEn(a_en), .iClr(a_clr), .iDvWe(a_we),
    .iDvDim(a_dim), .iDvIdx(a_idx), .iDvData(a_data),
    .oRand(a_rand), .oCnt(a_cnt), .oWrap(a_wrap)
  );

  sobolrng_md #(.BITWIDTH(5), .NUM_DIM(3)) dut_b (
    .iClk(clk), .iRst(b_rst), .iEn(b_en), .iClr(b_clr), .iDvWe(b_we),
    .iDvDim(b_dim), .iDvIdx(b_idx), .iDvData(b_data),
    .oRand(b_rand), .oCnt(b_cnt), .oWrap(b_wrap)
  );

  int checks = 0;
  int errors = 0;
  int mva [2][8];
  int mvb [3][5];

  // Sample n = XOR of the direction vectors selected by the set bits of gray(n)
  function automatic int sob_a(input int d, input int n);
    int g, x;
    g = n ^ (n >> 1);
    x = 0;
    for (int k = 0; k < 8; k++) if (g[k]) x = x ^ mva[d][k];
    return x;
  endfunction

  function automatic int sob_b(input int d, input int n);
    int g, x;
    g = n ^ (n >> 1);
    x = 0;
    for (int k = 0; k < 5; k++) if (g[k]) x = x ^ mvb[d][k];
    return x;
  endfunction

  function automatic void defaults_a();
    for (int d = 0; d < 2; d++) for (int k = 0; k < 8; k++) mva[d][k] = 1 << (7 - k);
  endfunction

  function automatic void defaults_b();
    for (int d = 0; d < 3; d++) for (int k = 0; k < 5; k++) mvb[d][k] = 1 << (4 - k);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    cyc(); cyc();
    a_rst = 1'b0; b_rst = 1'b0;
    defaults_a(); defaults_b();
    checks++;
    if (a_cnt !== 8'd0 || a_rand !== 16'd0 || a_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: cnt=%0d rand=%h wrap=%b expected 0/0/0", a_cnt, a_rand, a_wrap);
    end
    checks++;
    if (b_cnt !== 5'd0 || b_rand !== 15'd0 || b_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: cnt=%0d rand=%h wrap=%b expected 0/0/0", b_cnt, b_rand, b_wrap);
    end
  endtask

  task automatic test_sequence();
    int tbl [8] = '{0, 128, 192, 64, 96, 224, 160, 32};
    a_en = 1'b1;
    for (int n = 1; n < 8; n++) begin
      cyc();
      checks++;
      if (a_cnt !== 8'(n) || int'(a_rand[7:0]) != tbl[n] || int'(a_rand[15:8]) != tbl[n]) begin
        errors++;
        $display("FAIL seq n=%0d: cnt=%0d d0=%0d d1=%0d expected %0d/%0d/%0d",
                 n, a_cnt, a_rand[7:0], a_rand[15:8], n, tbl[n], tbl[n]);
      end
    end
    a_en = 1'b0;
  endtask

  task automatic test_wrap();
    int seen [256];
    int n, bad;
    for (int i = 0; i < 256; i++) seen[i] = 0;
    seen[0] = 1;
    a_clr = 1'b1; cyc(); a_clr = 1'b0;
    a_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cyc();
      n = (i + 1) % 256;
      if (n != 0) seen[a_rand[7:0]]++;
      checks++;
      if (a_cnt !== 8'(n) || a_wrap !== (n == 0) || int'(a_rand[7:0]) != sob_a(0, n) ||
          int'(a_rand[15:8]) != sob_a(1, n)) begin
        errors++;
        $display("FAIL wrap n=%0d: cnt=%0d wrap=%b d0=%0d d1=%0d expected %0d/%b/%0d/%0d",
                 n, a_cnt, a_wrap, a_rand[7:0], a_rand[15:8], n, n == 0, sob_a(0, n), sob_a(1, n));
      end
    end
    a_en = 1'b0;
    cyc();
    checks++;
    if (a_wrap !== 1'b0 || a_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_hold: wrap=%b cnt=%0d expected 0/0", a_wrap, a_cnt);
    end
    bad = 0;
    for (int v = 0; v < 256; v++) if (seen[v] != 1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL coverage: %0d values not hit exactly once, expected 0", bad);
    end
  endtask

  task automatic test_load_dim1();
    int vals [8] = '{128, 192, 160, 240, 136, 204, 170, 255};
    int early [4] = '{0, 128, 64, 192};
    a_en = 1'b1;
    cyc(); cyc();
    a_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a_we = 1'b1; a_dim = 1'b1; a_idx = 3'(k); a_data = 8'(vals[k]);
      a_clr = (k == 7);
      cyc();
      mva[1][k] = vals[k];
    end
    a_we = 1'b0; a_clr = 1'b0;
    checks++;
    if (a_cnt !== 8'd0 || a_rand !== 16'd0) begin
      errors++;
      $display("FAIL load_clr: cnt=%0d rand=%h expected 0/0", a_cnt, a_rand);
    end
    a_en = 1'b1;
    for (int n = 1; n < 9; n++) begin
      cyc();
      checks++;
      if (int'(a_rand[15:8]) != sob_a(1, n) || (n < 4 && int'(a_rand[15:8]) != early[n]) ||
          int'(a_rand[7:0]) != sob_a(0, n)) begin
        errors++;
        $display("FAIL load n=%0d: d1=%0d d0=%0d expected %0d/%0d",
                 n, a_rand[15:8], a_rand[7:0], sob_a(1, n), sob_a(0, n));
      end
    end
    a_en = 1'b0;
  endtask

  task automatic test_toggle();
    int n;
    a_clr = 1'b1; cyc(); a_clr = 1'b0;
    n = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 4) a_en = (c == 0 || c == 3);
      else a_en = 1'($urandom % 2);
      a_clr = (c == 5);
      cyc();
      if (a_clr) n = 0;
      else if (a_en) n = (n + 1) % 256;
      checks++;
      if (a_cnt !== 8'(n) || a_wrap !== 1'b0 || int'(a_rand[7:0]) != sob_a(0, n) ||
          int'(a_rand[15:8]) != sob_a(1, n)) begin
        errors++;
        $display("FAIL toggle c=%0d: cnt=%0d wrap=%b d0=%0d d1=%0d expected %0d/0/%0d/%0d",
                 c, a_cnt, a_wrap, a_rand[7:0], a_rand[15:8], n, sob_a(0, n), sob_a(1, n));
      end
    end
    a_en = 1'b0; a_clr = 1'b0;
  endtask

  task automatic test_ignored_writes();
    int n;
    a_we = 1'b1; a_dim = 1'b0; a_idx = 3'($urandom); a_data = 8'($urandom | 1);
    cyc();
    a_we = 1'b0; a_clr = 1'b1; cyc(); a_clr = 1'b0;
    a_en = 1'b1;
    for (int i = 1; i < 5; i++) begin
      cyc();
      checks++;
      if (int'(a_rand[7:0]) != sob_a(0, i)) begin
        errors++;
        $display("FAIL dim0_ro n=%0d: d0=%0d expected %0d", i, a_rand[7:0], sob_a(0, i));
      end
    end
    a_en = 1'b0;

    b_we = 1'b1;
    b_dim = 2'd3; b_idx = 3'($urandom_range(0, 4)); b_data = 5'($urandom); cyc();
    b_dim = 2'd1; b_idx = 3'd5; b_data = 5'($urandom); cyc();
    b_dim = 2'd2; b_idx = 3'd7; b_data = 5'($urandom); cyc();
    b_dim = 2'd0; b_idx = 3'd0; b_data = 5'($urandom); cyc();
    b_dim = 2'd2; b_idx = 3'd1; b_data = 5'd31; b_clr = 1'b1; cyc();
    mvb[2][1] = 31;
    b_we = 1'b0; b_clr = 1'b0;
    b_en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      cyc();
      n = (i + 1) % 32;
      checks++;
      if (b_cnt !== 5'(n) || b_wrap !== (n == 0) || int'(b_rand[4:0]) != sob_b(0, n) ||
          int'(b_rand[9:5]) != sob_b(1, n) || int'(b_rand[14:10]) != sob_b(2, n)) begin
        errors++;
        $display("FAIL b_seq n=%0d: cnt=%0d wrap=%b d0=%0d d1=%0d d2=%0d expected %0d/%b/%0d/%0d/%0d",
                 n, b_cnt, b_wrap, b_rand[4:0], b_rand[9:5], b_rand[14:10],
                 n, n == 0, sob_b(0, n), sob_b(1, n), sob_b(2, n));
      end
    end
    b_en = 1'b0;
  endtask

  task automatic test_write_step();
    int old_v, new_v;
    a_clr = 1'b1; cyc(); a_clr = 1'b0;
    old_v = mva[1][0];
    new_v = (old_v ^ int'($urandom_range(1, 255))) & 255;
    a_en = 1'b1; a_we = 1'b1; a_dim = 1'b1; a_idx = 3'd0; a_data = 8'(new_v);
    cyc();
    a_en = 1'b0; a_we = 1'b0;
    checks++;
    if (int'(a_rand[15:8]) != old_v) begin
      errors++;
      $display("FAIL write_step_old: d1=%0d expected %0d", a_rand[15:8], old_v);
    end
    mva[1][0] = new_v;
    a_clr = 1'b1; cyc(); a_clr = 1'b0;
    a_en = 1'b1; cyc(); a_en = 1'b0;
    checks++;
    if (int'(a_rand[15:8]) != sob_a(1, 1)) begin
      errors++;
      $display("FAIL write_step_new: d1=%0d expected %0d", a_rand[15:8], sob_a(1, 1));
    end
  endtask

  task automatic test_reset_mid();
    a_en = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    a_rst = 1'b1; a_we = 1'b1; a_dim = 1'b1; a_idx = 3'd2; a_data = 8'($urandom);
    cyc();
    a_rst = 1'b0; a_we = 1'b0; a_en = 1'b0;
    defaults_a();
    checks++;
    if (a_cnt !== 8'd0 || a_rand !== 16'd0 || a_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: cnt=%0d rand=%h wrap=%b expected 0/0/0", a_cnt, a_rand, a_wrap);
    end
    a_en = 1'b1;
    for (int n = 1; n < 9; n++) begin
      cyc();
      checks++;
      if (int'(a_rand[15:8]) != sob_a(1, n) || int'(a_rand[7:0]) != sob_a(0, n)) begin
        errors++;
        $display("FAIL reset_vec n=%0d: d1=%0d d0=%0d expected %0d/%0d",
                 n, a_rand[15:8], a_rand[7:0], sob_a(1, n), sob_a(0, n));
      end
    end
    a_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wrap();
    test_load_dim1();
    test_toggle();
    test_ignored_writes();
    test_write_step();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
